// File: rtl/avalon_rr_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM slave port among NUM_MASTERS requesters.
// A grant is held for a whole transaction (write burst, or read command plus all data beats).
module avalon_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int BURST_W     = 8
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_i,
  input  logic [NUM_MASTERS*AW-1:0]      m_address_i,
  input  logic [NUM_MASTERS*DW-1:0]      m_writedata_i,
  input  logic [NUM_MASTERS*DW/8-1:0]    m_byteenable_i,
  input  logic [NUM_MASTERS*BURST_W-1:0] m_burstcount_i,
  input  logic [NUM_MASTERS-1:0]         m_read_i,
  input  logic [NUM_MASTERS-1:0]         m_write_i,
  output logic [NUM_MASTERS-1:0]         m_waitrequest_o,
  output logic [DW-1:0]                  m_readdata_o,
  output logic [NUM_MASTERS-1:0]         m_readdatavalid_o,
  output logic [AW-1:0]                  s_address_o,
  output logic [DW-1:0]                  s_writedata_o,
  output logic [DW/8-1:0]                s_byteenable_o,
  output logic [BURST_W-1:0]             s_burstcount_o,
  output logic                           s_read_o,
  output logic                           s_write_o,
  input  logic                           s_waitrequest_i,
  input  logic                           s_readdatavalid_i,
  input  logic [DW-1:0]                  s_readdata_i,
  output logic [NUM_MASTERS-1:0]         grant_o
);

  localparam int IDXW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int BEW  = DW / 8;
  localparam int CNTW = BURST_W + 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ_CMD, READ_DATA} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDXW-1:0]        last_q, last_d;
  logic [CNTW-1:0]        burst_q, burst_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;

  logic [NUM_MASTERS-1:0] req;
  logic                   found;
  logic [IDXW-1:0]        pick_idx;
  int                     idx;

  logic [AW-1:0]          mux_addr;
  logic [DW-1:0]          mux_wdata;
  logic [BEW-1:0]         mux_be;
  logic [BURST_W-1:0]     mux_bc;
  logic                   mux_rd;
  logic                   mux_wr;
  logic [CNTW-1:0]        bc_eff;
  logic [CNTW-1:0]        cnt_inc;

  assign req = m_read_i | m_write_i;

  // Search starts just after the last granted master and wraps around.
  always_comb begin
    found    = 1'b0;
    pick_idx = last_q;
    idx      = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = (int'(last_q) + i) % NUM_MASTERS;
      if (!found && req[idx]) begin
        found    = 1'b1;
        pick_idx = idx[IDXW-1:0];
      end
    end
  end

  // AND-OR mux: an all-zero grant drives zeros onto the slave side.
  always_comb begin
    mux_addr  = '0;
    mux_wdata = '0;
    mux_be    = '0;
    mux_bc    = '0;
    mux_rd    = 1'b0;
    mux_wr    = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (grant_q[k]) begin
        mux_addr  = mux_addr  | m_address_i[k*AW +: AW];
        mux_wdata = mux_wdata | m_writedata_i[k*DW +: DW];
        mux_be    = mux_be    | m_byteenable_i[k*BEW +: BEW];
        mux_bc    = mux_bc    | m_burstcount_i[k*BURST_W +: BURST_W];
        mux_rd    = mux_rd    | m_read_i[k];
        mux_wr    = mux_wr    | m_write_i[k];
      end
    end
  end

  assign bc_eff  = (mux_bc == '0) ? CNTW'(1) : {1'b0, mux_bc};
  assign cnt_inc = cnt_q + CNTW'(1);

  assign s_address_o    = mux_addr;
  assign s_writedata_o  = mux_wdata;
  assign s_byteenable_o = mux_be;
  assign s_burstcount_o = mux_bc;
  assign s_write_o      = (state_q == WRITE)    && mux_wr;
  assign s_read_o       = (state_q == READ_CMD) && mux_rd;
  assign grant_o        = grant_q;
  assign m_readdata_o   = s_readdata_i;

  assign m_readdatavalid_o = (state_q == READ_DATA && s_readdatavalid_i) ? grant_q : '0;

  always_comb begin
    m_waitrequest_o = '1;
    if (state_q == WRITE || state_q == READ_CMD)
      m_waitrequest_o = ~grant_q | {NUM_MASTERS{s_waitrequest_i}};
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = NUM_MASTERS'(1) << pick_idx;
          last_d  = pick_idx;
          cnt_d   = '0;
          state_d = m_write_i[pick_idx] ? WRITE : READ_CMD;
        end
      end
      WRITE: begin
        if (s_write_o && !s_waitrequest_i) begin
          if (cnt_q == '0)
            burst_d = bc_eff;
          cnt_d = cnt_inc;
          if (cnt_inc == ((cnt_q == '0) ? bc_eff : burst_q)) begin
            state_d = IDLE;
            grant_d = '0;
            cnt_d   = '0;
          end
        end
      end
      READ_CMD: begin
        if (s_read_o && !s_waitrequest_i) begin
          burst_d = bc_eff;
          cnt_d   = '0;
          state_d = READ_DATA;
        end
      end
      READ_DATA: begin
        if (s_readdatavalid_i) begin
          cnt_d = cnt_inc;
          if (cnt_inc == burst_q) begin
            state_d = IDLE;
            grant_d = '0;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDXW'(NUM_MASTERS - 1);
      burst_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/avalon_rr_arbiter.md
# avalon_rr_arbiter

Round-robin arbiter that shares the single Avalon-MM slave port of the avalon_to_wb_bridge between NUM_MASTERS Avalon-MM requesters. It sits directly in front of the bridge on the wb_clk_i domain. It grants one master at a time and holds the grant for a complete transaction: a single write, a write burst, or a read command plus all of its readdatavalid beats. Only one transaction is outstanding at a time.

## Interface
- NUM_MASTERS, 2, number of requesters (2..8)
- AW, 32, address width
- DW, 32, data width
- BURST_W, 8, burstcount width
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  asynchronous, active-high reset
- m_address_i  in  NUM_MASTERS*AW  per-master address; master k occupies bits [k*AW +: AW] (same packing for all m_* vectors)
- m_writedata_i  in  NUM_MASTERS*DW  write data
- m_byteenable_i  in  NUM_MASTERS*DW/8  byte enables
- m_burstcount_i  in  NUM_MASTERS*BURST_W  burst length
- m_read_i, m_write_i  in  NUM_MASTERS  command strobes
- m_waitrequest_o  out  NUM_MASTERS  per-master stall
- m_readdata_o  out  DW  read data, broadcast to all masters
- m_readdatavalid_o  out  NUM_MASTERS  read data valid, granted master only
- s_address_o, s_writedata_o, s_byteenable_o, s_burstcount_o  out  AW/DW/DW/8/BURST_W  to bridge
- s_read_o, s_write_o  out  1  to bridge
- s_waitrequest_i, s_readdatavalid_i  in  1  from bridge
- s_readdata_i  in  DW  from bridge
- grant_o  out  NUM_MASTERS  one-hot current grant, 0 in IDLE

## Operation
- Request of master k: m_read_i[k] | m_write_i[k]. If both are set, write wins; the read is ignored for that transaction.
- State IDLE:
  - No master is forwarded. s_read_o = s_write_o = 0. All m_waitrequest_o = 1.
  - If any request is pending, grant the first requester searching from last_grant+1 upward, modulo NUM_MASTERS.
  - Register the grant, update last_grant, and go to WRITE or READ_CMD.
- State WRITE:
  - Granted master's signals are forwarded to s_*. Its m_waitrequest_o = s_waitrequest_i; all others = 1.
  - A beat is accepted when s_write_o & ~s_waitrequest_i.
  - Burstcount is latched from the first accepted beat. Burstcount 0 is treated as 1.
  - After the final beat, go to IDLE.
  - If the master deasserts write mid-burst, the grant is held and s_write_o follows the master.
- State READ_CMD:
  - Forwarding is the same as in WRITE, with s_read_o driven.
  - When ~s_waitrequest_i, latch burstcount (0 treated as 1) and go to READ_DATA.
- State READ_DATA:
  - s_read_o = 0. The granted master's m_waitrequest_o = 1.
  - s_readdata_i is passed through to m_readdata_o. s_readdatavalid_i is routed to the granted master's m_readdatavalid_o.
  - Beats are counted. When the count reaches burstcount, go to IDLE.
- s_readdatavalid_i arriving in IDLE/WRITE/READ_CMD is dropped; no m_readdatavalid_o is asserted.
- Beat counter is BURST_W+1 bits wide, so burstcount 2^BURST_W−1 does not wrap.

## Timing
- Reset values (asynchronous, immediate):
  - State = IDLE; last_grant = NUM_MASTERS−1, so master 0 wins first.
  - grant_o = 0; s_read_o = s_write_o = 0; s_address/writedata/byteenable/burstcount = 0.
  - m_waitrequest_o = all ones; m_readdatavalid_o = 0.
- Reset mid-transaction: the transaction is abandoned immediately with the same values; late read data after reset is dropped.
- Grant latency:
  - A request first seen in IDLE at cycle N is forwarded to the bridge at N+1.
  - With no bridge stall, a single write completes at N+1.
- Every transaction ends with at least one IDLE cycle. Back-to-back requesters therefore see a minimum 2-cycle period per single-beat transaction.
- m_readdata_o / m_readdatavalid_o are combinational from the bridge (zero added latency). s_* command outputs are combinational muxes of the registered grant.
- A master request arriving in the same cycle the current transaction finishes is considered in the following IDLE cycle.

## Test plan
- Reset, then master 0 writes addr 0x10, data 0xDEADBEEF, burstcount 1, bridge waitrequest low -> s_write_o high for exactly 1 cycle at N+1 with that address/data; grant_o = 0b01; IDLE the following cycle.
- Masters 0 and 1 each issue continuous single writes -> grants alternate 0,1,0,1; a 10-cycle window yields 5 grants with none lost.
- Master 1 reads with burstcount 4; bridge stalls the command 3 cycles, then returns 4 readdatavalid beats with gaps -> master 0's write waits until the 4th beat; m_readdatavalid_o asserts only bit 1, 4 times.
- Master 0 write burst of 3 with waitrequest toggling; master 0 drops write for 2 cycles mid-burst -> master 1 stays stalled until exactly 3 beats are accepted.
- Spurious s_readdatavalid_i in IDLE, and m_read_i = m_write_i = 1 on master 0 -> no m_readdatavalid_o asserted; write issued, not read.
- Assert wb_rst_i during READ_DATA after 2 of 4 beats -> outputs return to reset values in the same cycle; the remaining 2 beats after reset are dropped; the next grant goes to master 0.
